port_arbiter: RTL and testbench
===============================

# port_arbiter

Per-output-port arbiter for the simple switch. Up to N_IN input FSMs can target the same output port, and this block shares that port's FIFO write interface among them. It grants one requester for a whole packet using round-robin priority. It drives each input's port_busy line so that losing or aborted inputs fall back to IDLE, and it enforces a maximum packet length.

## Interface
- N_IN, 4: number of input requesters; valid range 2..8.
- W_WIDTH, 8: data byte width.
- MAX_LEN, 64: maximum bytes written per grant; range 1..255.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_IN  per-input write request (wr_en of each input FSM).
- data_in  in  N_IN*W_WIDTH  flattened input bytes; input i occupies bits [i*W_WIDTH +: W_WIDTH].
- fifo_full  in  1  output FIFO cannot accept a byte this cycle.
- busy  out  N_IN  per-input port_busy.
- grant  out  N_IN  one-hot current owner; all zeros when there is no owner.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_data  out  W_WIDTH  FIFO write byte.
- timeout_err  out  1  one-cycle pulse when MAX_LEN is exceeded.

## Operation
- Reset values: busy=0, grant=0, fifo_wr_en=0, fifo_data=0, timeout_err=0, rr pointer ptr=0, len=0, state=IDLE.
- All outputs are registered.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - busy is set to {N_IN{fifo_full}}.
  - If (req != 0) and !fifo_full, the winner is the first set req bit at or after ptr, searching cyclically.
  - On a win: grant<=onehot(winner), busy<=~onehot(winner), fifo_wr_en<=1, fifo_data<=data_in[winner], len<=1, go to GRANT.
- GRANT, owner o, evaluated in priority order:
  1. !req[o] (end of packet): fifo_wr_en<=0, ptr<=(o+1) mod N_IN, go to RELEASE.
  2. fifo_full: busy[o]<=1 so the owner aborts, fifo_wr_en<=0, ptr advances, go to RELEASE; counts as a drop.
  3. len==MAX_LEN: timeout_err<=1 for one cycle, busy[o]<=1, fifo_wr_en<=0, ptr advances, go to RELEASE.
  4. Otherwise: fifo_wr_en<=1, fifo_data<=data_in[o], len<=len+1.
- RELEASE: lasts exactly one cycle; grant<=0, busy<=all ones, len<=0, then go to IDLE.
- Losing requesters see busy asserted one cycle after contention. Their input FSMs abort and never write.
- len width is $clog2(MAX_LEN+1); len never wraps.
- ptr width is $clog2(N_IN); it wraps from N_IN-1 to 0.

## Timing
- A byte presented on data_in[o] with req[o] high in cycle t appears on fifo_data with fifo_wr_en=1 in cycle t+1.
- Arbitration latency is zero extra cycles: the first byte of the winner is written.
- fifo_full is sampled in the same cycle as the req it blocks.
- A byte that arrives in the cycle fifo_full is seen is not written.
- Minimum gap between two grants is 2 cycles: the RELEASE cycle plus the IDLE evaluation cycle.
- A previous owner that requests again in IDLE is deprioritised, because ptr already points past it.
- Reset mid-packet clears everything immediately; no partial write is completed.

## Configuration
- PORT_ARB_STATS_EN defined: adds output drop_cnt, 16 bits.
  - drop_cnt increments on every fifo_full abort and every timeout.
  - It saturates at 16'hFFFF and resets to 0.
- PORT_ARB_STATS_EN undefined: drop_cnt and its logic are absent; all other behaviour is identical.

## Structure
- switch_pkg holds:
  - the arb_state_t enum (IDLE, GRANT, RELEASE);
  - SOF_BYTE (8'hFF), shared with the input FSM;
  - the default W_WIDTH constant.
- Sub-module rr_picker: combinational rotating-priority encoder.
  - Inputs: req, ptr.
  - Outputs: valid, one-hot win, win index.
  - Instantiated once.

## Test plan
- req=4'b0001 for 5 cycles with bytes 0xFF,0x02,0xA1,0xA2,0xA3:
  - grant=0001;
  - fifo_wr_en high for 5 cycles starting one cycle later, with the same bytes in order;
  - busy=1110 throughout;
  - RELEASE, then ptr=1.
- req=4'b1010 asserted together with ptr=0:
  - input 1 wins;
  - busy[3]=1 on the next cycle;
  - only input 1's bytes reach the FIFO.
- Back-to-back packets, req=4'b0011 held continuously:
  - grants alternate 0001, 0010, 0001;
  - exactly 2 idle cycles between consecutive fifo_wr_en runs.
- fifo_full raised on the 3rd byte of a grant to input 2:
  - busy[2]=1 next cycle;
  - only 2 bytes written;
  - drop_cnt=1 with PORT_ARB_STATS_EN.
- MAX_LEN=4 with req[0] held for 10 cycles:
  - exactly 4 writes;
  - timeout_err pulses once;
  - busy[0]=1.
- rst_n low for 1 cycle mid-grant:
  - all outputs return to 0 asynchronously;
  - ptr=0;
  - the next request is arbitrated from IDLE.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: shared types and constants for the switch output-port logic
package switch_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
    localparam logic [7:0] SOF_BYTE = 8'hFF;
    localparam int DEF_W_WIDTH = 8;
endpackage

// File: rtl/port_arbiter_rr_picker.sv
// rr_picker: rotating-priority encoder, first set req bit at or after ptr
module rr_picker #(
    parameter int N_IN = 4,
    localparam int PW = $clog2(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [N_IN-1:0] win,
    output logic [PW-1:0]   win_idx
);
    // Scan from the farthest slot down so the closest set bit to ptr is kept last
    always_comb begin
        valid = 1'b0;
        win_idx = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_IN]) begin
                valid = 1'b1;
                win_idx = PW'((int'(ptr) + k) % N_IN);
            end
        end
        win = valid ? (N_IN'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: per-packet round-robin owner of one output FIFO write port; PORT_ARB_STATS_EN adds drop_cnt
module port_arbiter
    import switch_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int W_WIDTH = DEF_W_WIDTH,
    parameter int MAX_LEN = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN-1:0]         req,
    input  logic [N_IN*W_WIDTH-1:0] data_in,
    input  logic                    fifo_full,
    output logic [N_IN-1:0]         busy,
    output logic [N_IN-1:0]         grant,
    output logic                    fifo_wr_en,
    output logic [W_WIDTH-1:0]      fifo_data,
    output logic                    timeout_err
`ifdef PORT_ARB_STATS_EN
    ,
    output logic [15:0]             drop_cnt
`endif
);
    localparam int PW = $clog2(N_IN);
    localparam int LW = $clog2(MAX_LEN + 1);

    arb_state_t         state, state_d;
    logic [PW-1:0]      ptr, ptr_d, owner, owner_d, owner_nx, win_idx;
    logic [LW-1:0]      len, len_d;
    logic [N_IN-1:0]    busy_d, grant_d, win;
    logic [W_WIDTH-1:0] data_d;
    logic               wr_d, to_d, win_valid, at_max;

    rr_picker #(.N_IN(N_IN)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (win_valid),
        .win    (win),
        .win_idx(win_idx)
    );

    assign owner_nx = (owner == PW'(N_IN - 1)) ? '0 : owner + 1'b1;
    assign at_max   = len == LW'(MAX_LEN);

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        len_d   = len;
        busy_d  = busy;
        grant_d = grant;
        data_d  = fifo_data;
        wr_d    = 1'b0;
        to_d    = 1'b0;
        case (state)
            IDLE: begin
                busy_d = {N_IN{fifo_full}};
                if (win_valid && !fifo_full) begin
                    grant_d = win;
                    busy_d  = ~win;
                    wr_d    = 1'b1;
                    data_d  = data_in[int'(win_idx) * W_WIDTH +: W_WIDTH];
                    len_d   = LW'(1);
                    owner_d = win_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    ptr_d   = owner_nx;
                    state_d = RELEASE;
                end else if (fifo_full || at_max) begin
                    busy_d[owner] = 1'b1;
                    to_d    = !fifo_full;
                    ptr_d   = owner_nx;
                    state_d = RELEASE;
                end else begin
                    wr_d   = 1'b1;
                    data_d = data_in[int'(owner) * W_WIDTH +: W_WIDTH];
                    len_d  = len + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                busy_d  = '1;
                len_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so no partial packet survives reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            len         <= '0;
            busy        <= '0;
            grant       <= '0;
            fifo_wr_en  <= 1'b0;
            fifo_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            owner       <= owner_d;
            len         <= len_d;
            busy        <= busy_d;
            grant       <= grant_d;
            fifo_wr_en  <= wr_d;
            fifo_data   <= data_d;
            timeout_err <= to_d;
        end
    end

`ifdef PORT_ARB_STATS_EN
    logic drop;
    assign drop = (state == GRANT) && req[owner] && (fifo_full || at_max);

    // Saturating count of fifo_full aborts and length timeouts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: directed and randomized checks of port_arbiter against a behavioural model
module tb_port_arbiter;
    localparam int MAXL = 64;

    logic        clk = 1'b0, rst_n = 1'b0, fifo_full = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  busy, grant, busy4, grant4;
    logic        wr, to, wr4, to4;
    logic [7:0]  fdata, fdata4;
`ifdef PORT_ARB_STATS_EN
    logic [15:0] drop, drop4;
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .fifo_full(fifo_full),
        .busy(busy), .grant(grant), .fifo_wr_en(wr), .fifo_data(fdata), .timeout_err(to)
`ifdef PORT_ARB_STATS_EN
        , .drop_cnt(drop)
`endif
    );

    port_arbiter #(.MAX_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .fifo_full(fifo_full),
        .busy(busy4), .grant(grant4), .fifo_wr_en(wr4), .fifo_data(fdata4), .timeout_err(to4)
`ifdef PORT_ARB_STATS_EN
        , .drop_cnt(drop4)
`endif
    );

    // Behavioural model of the default-parameter instance
    int         m_st, m_own, m_ptr, m_len, m_drop, m_win;
    logic [3:0] m_busy, m_grant, m_one;
    logic [7:0] m_data;
    logic       m_wr, m_to;

    function automatic int pick(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    assign m_win = pick(req, m_ptr);
    assign m_one = 4'b0001 << m_win;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0; m_own <= 0; m_ptr <= 0; m_len <= 0; m_drop <= 0;
            m_busy <= '0; m_grant <= '0; m_data <= '0; m_wr <= 1'b0; m_to <= 1'b0;
        end else begin
            m_wr <= 1'b0;
            m_to <= 1'b0;
            if (m_st == 0) begin
                m_busy <= {4{fifo_full}};
                if (req != 0 && !fifo_full) begin
                    m_own <= m_win; m_grant <= m_one; m_busy <= ~m_one;
                    m_wr <= 1'b1; m_data <= data_in[m_win*8 +: 8]; m_len <= 1; m_st <= 1;
                end
            end else if (m_st == 1) begin
                if (!req[m_own]) begin
                    m_ptr <= (m_own + 1) % 4; m_st <= 2;
                end else if (fifo_full || m_len == MAXL) begin
                    m_busy[m_own] <= 1'b1; m_to <= !fifo_full;
                    m_ptr <= (m_own + 1) % 4; m_st <= 2;
                    if (m_drop < 65535) m_drop <= m_drop + 1;
                end else begin
                    m_wr <= 1'b1; m_data <= data_in[m_own*8 +: 8]; m_len <= m_len + 1;
                end
            end else begin
                m_grant <= '0; m_busy <= '1; m_len <= 0; m_st <= 0;
            end
        end
    end

    task automatic do_reset();
        req = '0; fifo_full = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (busy !== 4'b0 || busy4 !== 4'b0) begin bad++; $display("FAIL reset_busy got=%b/%b exp=0000", busy, busy4); end
        total++; if (grant !== 4'b0 || grant4 !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b/%b exp=0000", grant, grant4); end
        total++; if (wr !== 1'b0 || to !== 1'b0 || fdata !== 8'h00) begin bad++; $display("FAIL reset_out wr=%b to=%b data=%h exp 0/0/00", wr, to, fdata); end
`ifdef PORT_ARB_STATS_EN
        total++; if (drop !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] b [5] = '{8'hFF, 8'h02, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 5; i++) begin
            req = 4'b0001; data_in[7:0] = b[i];
            @(negedge clk);
            total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant%0d got=%b exp=0001", i, grant); end
            total++; if (busy !== 4'b1110) begin bad++; $display("FAIL single_busy%0d got=%b exp=1110", i, busy); end
            total++; if (wr !== 1'b1 || fdata !== b[i]) begin bad++; $display("FAIL single_byte%0d wr=%b data=%h exp 1/%h", i, wr, fdata, b[i]); end
        end
        req = '0;
        @(negedge clk);
        total++; if (wr !== 1'b0 || grant !== 4'b0001) begin bad++; $display("FAIL single_end wr=%b grant=%b exp 0/0001", wr, grant); end
        @(negedge clk);
        total++; if (grant !== 4'b0 || busy !== 4'b1111) begin bad++; $display("FAIL single_release grant=%b busy=%b exp 0000/1111", grant, busy); end
        @(negedge clk);
        total++; if (busy !== 4'b0) begin bad++; $display("FAIL single_idle busy=%b exp 0000", busy); end
        req = 4'b0011;
        @(negedge clk);
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_ptr grant=%b exp 0010", grant); end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req = 4'b1010; data_in[15:8] = 8'h11 + 8'(i); data_in[31:24] = 8'h33 + 8'(i);
            @(negedge clk);
            total++; if (grant !== 4'b0010 || busy !== 4'b1101) begin bad++; $display("FAIL cont_grant%0d grant=%b busy=%b exp 0010/1101", i, grant, busy); end
            total++; if (wr !== 1'b1 || fdata !== 8'h11 + 8'(i)) begin bad++; $display("FAIL cont_data%0d wr=%b data=%h exp 1/%h", i, wr, fdata, 8'h11 + 8'(i)); end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] starts[$];
        int lens[$], gaps[$], run_len, gap, pulses;
        logic prev;
        do_reset();
        req = 4'b0011; prev = 1'b0; run_len = 0; gap = 0; pulses = 0;
        for (int c = 0; c < 215; c++) begin
            data_in = $urandom;
            @(negedge clk);
            if (to) pulses++;
            if (wr) begin
                if (!prev) begin
                    starts.push_back(grant);
                    if (starts.size() > 1) gaps.push_back(gap);
                end
                run_len++; gap = 0;
            end else begin
                if (prev) begin lens.push_back(run_len); run_len = 0; end
                gap++;
            end
            prev = wr;
        end
        req = '0;
        repeat (3) @(negedge clk);
        total++;
        if (starts.size() < 3 || lens.size() < 2) begin
            bad++; $display("FAIL b2b_runs got=%0d exp>=3", starts.size());
        end else begin
            if (starts[0] !== 4'b0001 || starts[1] !== 4'b0010 || starts[2] !== 4'b0001) begin
                bad++; $display("FAIL b2b_order got=%b,%b,%b exp 0001,0010,0001", starts[0], starts[1], starts[2]);
            end
            total++; if (gaps[0] != 2 || gaps[1] != 2) begin bad++; $display("FAIL b2b_gap got=%0d,%0d exp 2,2", gaps[0], gaps[1]); end
            total++; if (lens[0] != MAXL || lens[1] != MAXL) begin bad++; $display("FAIL b2b_len got=%0d,%0d exp %0d", lens[0], lens[1], MAXL); end
        end
        total++; if (pulses < 2) begin bad++; $display("FAIL b2b_timeouts got=%0d exp>=2", pulses); end
    endtask

    task automatic test_fifo_full();
        int n;
        do_reset();
        n = 0;
        for (int i = 0; i < 3; i++) begin
            req = 4'b0100; data_in[23:16] = 8'h20 + 8'(i); fifo_full = (i == 2);
            @(negedge clk);
            if (wr) n++;
            if (i < 2) begin
                total++; if (wr !== 1'b1 || fdata !== 8'h20 + 8'(i)) begin bad++; $display("FAIL full_byte%0d wr=%b data=%h exp 1/%h", i, wr, fdata, 8'h20 + 8'(i)); end
            end
        end
        total++; if (busy[2] !== 1'b1 || to !== 1'b0) begin bad++; $display("FAIL full_abort busy=%b to=%b exp busy[2]=1 to=0", busy, to); end
        req = '0; fifo_full = 1'b0;
        repeat (3) begin @(negedge clk); if (wr) n++; end
        total++; if (n != 2) begin bad++; $display("FAIL full_count got=%0d exp=2", n); end
`ifdef PORT_ARB_STATS_EN
        total++; if (drop !== 16'd1) begin bad++; $display("FAIL full_drop got=%0d exp=1", drop); end
`endif
        fifo_full = 1'b1; req = 4'b0001;
        @(negedge clk);
        total++; if (busy !== 4'b1111 || grant !== 4'b0 || wr !== 1'b0) begin bad++; $display("FAIL full_idle busy=%b grant=%b wr=%b exp 1111/0000/0", busy, grant, wr); end
        fifo_full = 1'b0; req = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n, pulses;
        logic aborted, busy_seen;
        do_reset();
        n = 0; pulses = 0; aborted = 1'b0; busy_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            req = aborted ? 4'b0 : 4'b0001; data_in[7:0] = 8'h40 + 8'(c);
            @(negedge clk);
            if (wr4) n++;
            if (to4) begin pulses++; busy_seen = busy4[0]; end
            if (grant4 != 4'b0 && busy4[0]) aborted = 1'b1;
        end
        total++; if (n != 4) begin bad++; $display("FAIL to_writes got=%0d exp=4", n); end
        total++; if (pulses != 1) begin bad++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
        total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL to_busy got=%b exp=1", busy_seen); end
`ifdef PORT_ARB_STATS_EN
        total++; if (drop4 !== 16'd1) begin bad++; $display("FAIL to_drop got=%0d exp=1", drop4); end
`endif
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010; data_in[15:8] = 8'h55;
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        req = 4'b0100;
        repeat (2) @(negedge clk);
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL mid_pre grant=%b exp 0100", grant); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 4'b0 || grant !== 4'b0 || wr !== 1'b0 || fdata !== 8'h00 || to !== 1'b0) begin
            bad++; $display("FAIL mid_async busy=%b grant=%b wr=%b data=%h to=%b exp all 0", busy, grant, wr, fdata, to);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1010; data_in[15:8] = 8'h66; data_in[31:24] = 8'h77;
        @(negedge clk);
        total++; if (grant !== 4'b0010 || wr !== 1'b1 || fdata !== 8'h66) begin bad++; $display("FAIL mid_rearb grant=%b wr=%b data=%h exp 0010/1/66", grant, wr, fdata); end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            fifo_full = ($urandom_range(0, 9) == 0);
            data_in = $urandom;
            @(negedge clk);
            total++; if (busy !== m_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_busy); end
            total++; if (grant !== m_grant) begin bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, grant, m_grant); end
            total++; if (wr !== m_wr || to !== m_to) begin bad++; $display("FAIL rnd_wr c=%0d wr=%b to=%b exp %b/%b", c, wr, to, m_wr, m_to); end
            if (m_wr) begin
                total++; if (fdata !== m_data) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, fdata, m_data); end
            end
`ifdef PORT_ARB_STATS_EN
            total++; if (drop !== 16'(m_drop)) begin bad++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, drop, m_drop); end
`endif
        end
        req = '0; fifo_full = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_fifo_full();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
